// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bundle: control inputs from hazard/decode/CP0, instruction
// memory port and the IF/ID-facing outputs of fetch_ctrl.
interface fetch_ctrl_if;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        if_exc;
  logic [4:0]  if_exccode;
  logic [31:0] fetch_cnt;

  modport master (
    output stall, br_valid, br_target, exc_req, eret_req, epc, im_instr,
    input  im_addr, if_pc, if_instr, if_valid, if_exc, if_exccode, fetch_cnt
  );

  modport slave (
    input  stall, br_valid, br_target, exc_req, eret_req, epc, im_instr,
    output im_addr, if_pc, if_instr, if_valid, if_exc, if_exccode, fetch_cnt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, picks the next PC from
// sequential/branch/exception/eret sources and flags faulting fetch addresses.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_LO      = 32'h0000_3000,
  parameter logic [31:0] IM_HI      = 32'h0000_4ffc
) (
  input  logic         clk,
  input  logic         reset,
  fetch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        fault_s;

  function automatic logic addr_fault(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr < IM_LO) || (addr > IM_HI);
  endfunction

  // Next-state, next-PC and fetch-counter selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        valid_d = 1'b1;
      end
      RUN, REDIR: begin
        valid_d = 1'b1;
        if (!bus.stall && valid_q) begin
          cnt_d = cnt_q + 32'd1;
        end else begin
          cnt_d = cnt_q;
        end
        // Redirects overrule stall; a branch seen under stall is dropped.
        if (bus.exc_req) begin
          pc_d    = HANDLER_PC;
          state_d = REDIR;
        end else if (bus.eret_req) begin
          pc_d    = bus.epc;
          state_d = REDIR;
        end else if (bus.stall) begin
          pc_d    = pc_q;
          state_d = RUN;
        end else if (bus.br_valid) begin
          pc_d    = bus.br_target;
          state_d = RUN;
        end else begin
          pc_d    = pc_q + 32'd4;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
        pc_d    = RESET_PC;
        valid_d = 1'b0;
      end
    endcase
  end

  // Sequencer state, PC and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign fault_s        = addr_fault(pc_q);
  assign bus.im_addr    = pc_q;
  assign bus.if_pc      = pc_q;
  assign bus.if_valid   = valid_q;
  assign bus.if_exc     = valid_q && fault_s;
  assign bus.if_exccode = (valid_q && fault_s) ? 5'd4 : 5'd0;
  assign bus.if_instr   = (valid_q && !fault_s) ? bus.im_instr : 32'd0;
  assign bus.fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: boot, sequential fetch, stall, branch,
// exception/eret redirects, address faults and asynchronous reset.
module tb_fetch_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fetch_ctrl_if bus ();

  fetch_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: each word is its address xor a fixed pattern.
  assign bus.im_instr = bus.im_addr ^ 32'hC0DE_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall     = 1'b0;
    bus.br_valid  = 1'b0;
    bus.br_target = 32'd0;
    bus.exc_req   = 1'b0;
    bus.eret_req  = 1'b0;
    bus.epc       = 32'd0;
  endtask

  // Observes a valid, non-faulting fetch at addr with the given count.
  task automatic expect_fetch(input string name, input logic [31:0] addr, input logic [31:0] cnt);
    checks++;
    if (bus.im_addr !== addr || bus.if_pc !== addr || bus.if_valid !== 1'b1 ||
        bus.if_exc !== 1'b0 || bus.if_instr !== (addr ^ 32'hC0DE_0000) || bus.fetch_cnt !== cnt) begin
      errors++;
      $display("FAIL %s: got addr=%h pc=%h v=%b exc=%b instr=%h cnt=%0d, expected addr=%h v=1 exc=0 instr=%h cnt=%0d",
               name, bus.im_addr, bus.if_pc, bus.if_valid, bus.if_exc, bus.if_instr, bus.fetch_cnt,
               addr, addr ^ 32'hC0DE_0000, cnt);
    end
  endtask

  // Observes a faulting fetch at addr with the given count.
  task automatic expect_fault(input string name, input logic [31:0] addr, input logic [31:0] cnt);
    checks++;
    if (bus.im_addr !== addr || bus.if_valid !== 1'b1 || bus.if_exc !== 1'b1 ||
        bus.if_exccode !== 5'd4 || bus.if_instr !== 32'd0 || bus.fetch_cnt !== cnt) begin
      errors++;
      $display("FAIL %s: got addr=%h v=%b exc=%b code=%0d instr=%h cnt=%0d, expected addr=%h v=1 exc=1 code=4 instr=0 cnt=%0d",
               name, bus.im_addr, bus.if_valid, bus.if_exc, bus.if_exccode, bus.if_instr, bus.fetch_cnt,
               addr, cnt);
    end
  endtask

  task automatic expect_boot(input string name);
    checks++;
    if (bus.im_addr !== 32'h0000_3000 || bus.if_pc !== 32'h0000_3000 || bus.if_valid !== 1'b0 ||
        bus.if_instr !== 32'd0 || bus.if_exc !== 1'b0 || bus.if_exccode !== 5'd0 || bus.fetch_cnt !== 32'd0) begin
      errors++;
      $display("FAIL %s: got addr=%h pc=%h v=%b instr=%h exc=%b code=%0d cnt=%0d, expected addr=00003000 v=0 instr=0 exc=0 code=0 cnt=0",
               name, bus.im_addr, bus.if_pc, bus.if_valid, bus.if_instr, bus.if_exc, bus.if_exccode, bus.fetch_cnt);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    expect_boot("reset_state");
    reset = 1'b0;
    #1;
    expect_boot("boot_cycle");
    step();
    expect_fetch("first_fetch", 32'h0000_3000, 32'd0);
    step();
    expect_fetch("seq_3004", 32'h0000_3004, 32'd1);
    step();
    expect_fetch("seq_3008", 32'h0000_3008, 32'd2);
    step();
    expect_fetch("seq_300c", 32'h0000_300c, 32'd3);
    step();
    expect_fetch("seq_3010", 32'h0000_3010, 32'd4);
  endtask

  task automatic test_stall();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_fetch("stall_hold", 32'h0000_3010, 32'd4);
    end
    bus.stall = 1'b0;
    step();
    expect_fetch("stall_release", 32'h0000_3014, 32'd5);
  endtask

  task automatic test_branch();
    step();
    step();
    step();
    expect_fetch("seq_3020", 32'h0000_3020, 32'd8);
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h0000_3100;
    bus.stall     = 1'b1;
    step();
    expect_fetch("branch_under_stall", 32'h0000_3020, 32'd8);
    bus.stall = 1'b0;
    step();
    expect_fetch("branch_taken", 32'h0000_3100, 32'd9);
    bus.br_valid = 1'b0;
  endtask

  task automatic test_exc_eret();
    bus.stall    = 1'b1;
    bus.exc_req  = 1'b1;
    bus.eret_req = 1'b1;
    bus.epc      = 32'h0000_3040;
    step();
    expect_fetch("exc_wins_under_stall", 32'h0000_4180, 32'd9);
    clear_inputs();
    bus.epc = 32'h0000_3040;
    step();
    expect_fetch("handler_seq_4184", 32'h0000_4184, 32'd10);
    step();
    expect_fetch("handler_seq_4188", 32'h0000_4188, 32'd11);
    bus.eret_req = 1'b1;
    step();
    expect_fetch("eret_to_epc", 32'h0000_3040, 32'd12);
    bus.eret_req = 1'b0;
  endtask

  task automatic test_fault();
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h0000_3002;
    step();
    expect_fault("misaligned_3002", 32'h0000_3002, 32'd13);
    bus.br_valid = 1'b0;
    step();
    expect_fault("misaligned_3006", 32'h0000_3006, 32'd14);
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h0000_5000;
    step();
    expect_fault("above_hi_5000", 32'h0000_5000, 32'd15);
    bus.br_target = 32'h0000_4ffc;
    step();
    expect_fetch("edge_hi_4ffc", 32'h0000_4ffc, 32'd16);
    bus.br_valid = 1'b0;
    step();
    expect_fault("past_hi_5000", 32'h0000_5000, 32'd17);
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h0000_2ffc;
    step();
    expect_fault("below_lo_2ffc", 32'h0000_2ffc, 32'd18);
    bus.br_valid = 1'b0;
  endtask

  task automatic test_wrap();
    bus.br_valid  = 1'b1;
    bus.br_target = 32'hffff_fffc;
    step();
    expect_fault("top_fffffffc", 32'hffff_fffc, 32'd19);
    bus.br_valid = 1'b0;
    step();
    expect_fault("wrap_to_0", 32'h0000_0000, 32'd20);
  endtask

  task automatic test_async_reset();
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h0000_3abc;
    step();
    expect_fetch("at_3abc", 32'h0000_3abc, 32'd21);
    bus.br_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    expect_boot("async_reset");
    step();
    expect_boot("async_reset_held");
    reset = 1'b0;
    step();
    expect_fetch("refetch_after_reset", 32'h0000_3000, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    clear_inputs();
    test_reset();
    test_stall();
    test_branch();
    test_exc_eret();
    test_fault();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
